mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Port: CLK  in  1  rising-edge clock for all state.
REQ-003 Port: RESET  in  1  asynchronous, active-low reset.
REQ-004 Port: I_READ  in  1  instruction-cache block read request.
REQ-005 Port: I_ADDRESS  in  6  instruction block address.
REQ-006 Port: I_READDATA  out  32  block returned to instruction cache (registered).
REQ-007 Port: I_BUSY  out  1  instruction-side stall.
REQ-008 Port: D_READ, D_WRITE  in  1 each  data-cache block read / write-back request.
REQ-009 Port: D_ADDRESS  in  6  data block address.
REQ-010 Port: D_WRITEDATA  in  32  write-back block.
REQ-011 Port: D_READDATA  out  32  block returned to data cache (registered).
REQ-012 Port: D_BUSY  out  1  data-side stall.
REQ-013 Port: M_READ, M_WRITE  out  1 each  main-memory strobes.
REQ-014 Port: M_ADDRESS  out  6  and M_WRITEDATA  out  32  main-memory address and data.
REQ-015 Port: M_READDATA  in  32  and M_BUSY  in  1  main-memory data and busywait.

Function
REQ-016 A requester SHALL be pending when I_READ=1 (I side) or D_READ|D_WRITE=1 (D side).
REQ-017 States SHALL be IDLE, I_WAIT, D_WAIT, RELEASE; owner register (I/D), last_owner register, seen flag.
REQ-018 IDLE: M_READ=M_WRITE=0; at posedge go to I_WAIT or D_WAIT per arbitration, clear seen, set owner.
REQ-019 Arbitration: single pending side wins; both pending -> side != last_owner; none -> stay IDLE.
REQ-020 X_WAIT: M_ADDRESS/M_WRITEDATA/M_READ/M_WRITE SHALL combinationally follow the owner's inputs; I side drives M_WRITE=0.
REQ-021 D_READ and D_WRITE both high SHALL be forwarded as write (M_WRITE=1, M_READ=0).
REQ-022 seen SHALL set at the posedge where M_BUSY=1 in X_WAIT.
REQ-023 X_WAIT -> RELEASE at the posedge where seen=1 and M_BUSY=0; same edge latches M_READDATA into owner's READDATA (reads only; write leaves it unchanged).
REQ-024 X_WAIT -> IDLE if owner deasserts its request while seen=0 (abort); no data latched, last_owner unchanged.
REQ-025 RELEASE lasts exactly one cycle: M_READ=M_WRITE=0, last_owner<=owner, next IDLE.
REQ-026 X_BUSY SHALL equal pending(X), except owner's BUSY=0 throughout RELEASE.
REQ-027 Non-owner pending side SHALL see BUSY=1 and SHALL NOT alter any M_* output.
REQ-028 M_ADDRESS and M_WRITEDATA SHALL be 0 outside X_WAIT.
REQ-029 Uncontended latency: grant at edge 1, memory busy N cycles, BUSY falls in RELEASE, min 3 cycles after request.
REQ-030 Requester re-asserting in the cycle after RELEASE SHALL be arbitrated normally (no back-to-back bypass of the other side).

Reset
REQ-031 RESET=0 SHALL immediately force IDLE, owner=I, last_owner=I, seen=0.
REQ-032 During and after reset all outputs SHALL be 0, including I_READDATA, D_READDATA, I_BUSY, D_BUSY.
REQ-033 Reset mid-transaction SHALL drop strobes at once; no data latched; first post-reset tie grants D.

Verification
REQ-034 I_READ alone, addr 0x05, memory busy 4 cycles returning 0xDEADBEEF -> M_READ=1 addr 0x05, I_READDATA=0xDEADBEEF, I_BUSY=0 for one cycle in RELEASE.
REQ-035 I_READ and D_WRITE same cycle after reset -> D served first (M_WRITE=1, M_WRITEDATA=D_WRITEDATA), I_BUSY=1 throughout, then I served.
REQ-036 Both sides requesting continuously for 4 transactions -> grants alternate D,I,D,I.
REQ-037 D_READ dropped before M_BUSY rises -> return to IDLE, D_READDATA unchanged, pending I granted next.
REQ-038 RESET=0 asserted mid D_WAIT with M_BUSY=1 -> M_READ=M_WRITE=0 and BUSY outputs 0 without waiting for a clock edge.
REQ-039 D_READ=D_WRITE=1 at addr 0x3F -> M_WRITE=1, M_READ=0, M_ADDRESS=0x3F.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_arbiter_if
// Bundles the three buses that meet at the memory arbiter:
//   I side : I_READ, I_ADDRESS (to arbiter); I_READDATA, I_BUSY (from arbiter)
//   D side : D_READ, D_WRITE, D_ADDRESS, D_WRITEDATA (to arbiter);
//            D_READDATA, D_BUSY (from arbiter)
//   M side : M_READ, M_WRITE, M_ADDRESS, M_WRITEDATA (from arbiter);
//            M_READDATA, M_BUSY (to arbiter)
// Modports:
//   master : the arbiter itself
//   slave  : everything around it (both caches and main memory)
// -----------------------------------------------------------------------------
interface mem_arbiter_if;
  logic        I_READ;
  logic [5:0]  I_ADDRESS;
  logic [31:0] I_READDATA;
  logic        I_BUSY;

  logic        D_READ;
  logic        D_WRITE;
  logic [5:0]  D_ADDRESS;
  logic [31:0] D_WRITEDATA;
  logic [31:0] D_READDATA;
  logic        D_BUSY;

  logic        M_READ;
  logic        M_WRITE;
  logic [5:0]  M_ADDRESS;
  logic [31:0] M_WRITEDATA;
  logic [31:0] M_READDATA;
  logic        M_BUSY;

  modport master (
    input  I_READ, I_ADDRESS,
    input  D_READ, D_WRITE, D_ADDRESS, D_WRITEDATA,
    input  M_READDATA, M_BUSY,
    output I_READDATA, I_BUSY,
    output D_READDATA, D_BUSY,
    output M_READ, M_WRITE, M_ADDRESS, M_WRITEDATA
  );

  modport slave (
    output I_READ, I_ADDRESS,
    output D_READ, D_WRITE, D_ADDRESS, D_WRITEDATA,
    output M_READDATA, M_BUSY,
    input  I_READDATA, I_BUSY,
    input  D_READDATA, D_BUSY,
    input  M_READ, M_WRITE, M_ADDRESS, M_WRITEDATA
  );
endinterface

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Shares one main-memory port between an instruction cache (read only) and a
// data cache (read / write-back). One transaction is in flight at a time; ties
// are broken against the side that was served last.
// Ports:
//   CLK   : rising-edge clock
//   RESET : asynchronous, active-low reset
//   bus   : mem_arbiter_if.master (I, D and M buses, see the interface file)
// -----------------------------------------------------------------------------
module mem_arbiter (
  input  logic          CLK,
  input  logic          RESET,
  mem_arbiter_if.master bus
);

  typedef enum logic [1:0] {IDLE, I_WAIT, D_WAIT, RELEASE} state_t;
  typedef enum logic {OWN_I = 1'b0, OWN_D = 1'b1} owner_t;

  state_t      state, state_d;
  owner_t      owner, owner_d;
  owner_t      last_owner, last_owner_d;
  logic        seen, seen_d;          // memory has raised M_BUSY for this grant
  logic [31:0] i_rdata, i_rdata_d;
  logic [31:0] d_rdata, d_rdata_d;

  logic        i_pend, d_pend;
  logic        m_read, m_write;
  logic [5:0]  m_addr;
  logic [31:0] m_wdata;
  logic        i_busy, d_busy;

  assign i_pend = bus.I_READ;
  assign d_pend = bus.D_READ | bus.D_WRITE;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of process order.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state      <= IDLE;
      owner      <= OWN_I;
      last_owner <= OWN_I;
      seen       <= 1'b0;
      i_rdata    <= '0;
      d_rdata    <= '0;
    end else begin
      state      <= state_d;
      owner      <= owner_d;
      last_owner <= last_owner_d;
      seen       <= seen_d;
      i_rdata    <= i_rdata_d;
      d_rdata    <= d_rdata_d;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default before the case, so no
    // path leaves a signal unassigned and no latch is inferred.
    state_d      = state;
    owner_d      = owner;
    last_owner_d = last_owner;
    seen_d       = seen;
    i_rdata_d    = i_rdata;
    d_rdata_d    = d_rdata;
    m_read       = 1'b0;
    m_write      = 1'b0;
    m_addr       = '0;
    m_wdata      = '0;

    unique case (state)
      IDLE: begin
        if (i_pend || d_pend) begin
          seen_d = 1'b0;
          if (i_pend && d_pend)
            owner_d = (last_owner == OWN_I) ? OWN_D : OWN_I;
          else
            owner_d = d_pend ? OWN_D : OWN_I;
          state_d = (owner_d == OWN_D) ? D_WAIT : I_WAIT;
        end
      end

      I_WAIT: begin
        m_read = bus.I_READ;
        m_addr = bus.I_ADDRESS;
        // Dropping the request before memory has started is an abort.
        if (!seen && !i_pend) begin
          state_d = IDLE;
        end else if (seen && !bus.M_BUSY) begin
          state_d   = RELEASE;
          i_rdata_d = bus.M_READDATA;
        end else if (bus.M_BUSY) begin
          seen_d = 1'b1;
        end
      end

      D_WAIT: begin
        // Read and write together is treated as a write-back.
        m_write = bus.D_WRITE;
        m_read  = bus.D_READ & ~bus.D_WRITE;
        m_addr  = bus.D_ADDRESS;
        m_wdata = bus.D_WRITEDATA;
        if (!seen && !d_pend) begin
          state_d = IDLE;
        end else if (seen && !bus.M_BUSY) begin
          state_d = RELEASE;
          if (!bus.D_WRITE)
            d_rdata_d = bus.M_READDATA;
        end else if (bus.M_BUSY) begin
          seen_d = 1'b1;
        end
      end

      RELEASE: begin
        last_owner_d = owner;
        state_d      = IDLE;
      end
    endcase

    // Busy mirrors the request, except the owner is released for the single
    // RELEASE cycle. RESET gates it so the stalls drop without a clock edge.
    i_busy = RESET & i_pend & ~((state == RELEASE) && (owner == OWN_I));
    d_busy = RESET & d_pend & ~((state == RELEASE) && (owner == OWN_D));
  end

  assign bus.M_READ      = m_read;
  assign bus.M_WRITE     = m_write;
  assign bus.M_ADDRESS   = m_addr;
  assign bus.M_WRITEDATA = m_wdata;
  assign bus.I_READDATA  = i_rdata;
  assign bus.D_READDATA  = d_rdata;
  assign bus.I_BUSY      = i_busy;
  assign bus.D_BUSY      = d_busy;

endmodule
